icache_assoc: RTL
=================

// Module: icache_assoc
// PURPOSE
//  Parametrised N-way (1 or 2) set-associative L1 instruction cache between the
//  fetch stage and the shared L2; next generation of the direct-mapped ICache.
//  Peeks DCache first for coherence, refills whole lines by L2 burst, and adds
//  LRU replacement, flush-all and refill poisoning on invalidate.
// PARAMETERS
//  SET_BITS    4  log2(number of sets)
//  WORD_BITS   3  log2(words per line); LINE_WORDS=2**WORD_BITS, <=16
//  WAYS        2  associativity, 1 (direct-mapped) or 2 (LRU)
//  derived: TAG_W=30-SET_BITS-WORD_BITS; LINE_W=TAG_W+SET_BITS
// PORTS
//  clk           in   1       clock; all state on rising edge
//  reset         in   1       asynchronous, active-low reset
//  rreq          in   1       fetch request, addr valid
//  addr          in   32      fetch byte address, [1:0] ignored
//  rdata         out  32      fetch data, valid when rreq & ~miss
//  miss          out  1       stall: data not available this cycle
//  peek_addr     out  32      = addr, to DCache
//  peek_rdata    in   32      DCache data
//  peek_miss     in   1       0: DCache holds addr, use peek_rdata
//  l2_rreq       out  1       one-cycle refill request pulse
//  l2_addr       out  32      line-aligned refill address
//  l2_burst_size out  5       = LINE_WORDS
//  l2_rdata      in   32      burst data
//  l2_busy       in   1       1: L2 not yet streaming
//  invalid_line  in   LINE_W  {tag,set} of line to invalidate
//  invalid_req   in   1       invalidate strobe (all ways)
//  flush_req     in   1       invalidate entire cache
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, all valid=0, LRU=0, l2_rreq=0,
//   l2_addr=0, l2_burst_size=0, poison=0. Tag/data arrays not reset.
//  Lookup (combinational, 0 latency): hit = any way valid & tag match at set.
//   rdata = peek_miss ? hit-way word : peek_rdata (0 if no hit and peek_miss).
//   miss = (rreq & peek_miss & ~hit) | (state != IDLE).
//  LRU (WAYS=2): one bit per set names victim; on hit by rreq in IDLE set LRU
//   to the other way; on refill start set LRU to other than filled way.
//   Victim: first invalid way (way0 preferred), else LRU way. WAYS=1: way0.
//  FSM:
//   IDLE : rreq & peek_miss & ~hit -> REQ; latch line addr, victim way;
//          l2_rreq<=1, l2_addr<={tag,set,0}, l2_burst_size<=LINE_WORDS;
//          write victim tag, clear victim valid.
//   REQ  : l2_rreq<=0 -> WAIT.
//   WAIT : first cycle l2_busy=0 -> FILL; that cycle's l2_rdata is word 0.
//   FILL : one word per cycle into victim at word counter; after word
//          LINE_WORDS-1: set valid unless poisoned, clear poison -> IDLE.
//  Fill order strictly word 0..LINE_WORDS-1; no critical-word-first.
//  Invalidate: clears valid of every way with matching set & tag, any state.
//   If it matches the line under refill (REQ/WAIT/FILL), set poison.
//  flush_req: clears all valid in 1 cycle; if not IDLE also sets poison.
//  Same-cycle invalidate/flush and fill completion of same line: line ends
//   invalid. Same-cycle invalidate and refill start: start wins tag write,
//   invalidate compares against new tag and poisons.
//  addr may change during refill; refill uses latched address only.
//  Reset mid-refill: abandon immediately; L2 burst in flight is ignored.
// STRUCTURE
//  icache_defs.vh: state encodings (`ICACHE_IDLE/REQ/WAIT/FILL), width macros.
//  Sub-module icache_way (x WAYS): tag/valid/data arrays for one way, hit
//   compare, word read, fill write port, invalidate/flush ports.
//  Top: FSM, word counter, LRU bits, victim select, peek mux.
// TESTING
//  Cold miss 0x1000, L2 busy 3 cyc, words 0xA0..0xA7 -> one l2_rreq, l2_addr
//   0x1000, size 8; miss held until fill ends; then rdata(0x101C)=0xA7.
//  Fill 0x1000 and 0x2000 (same set 0) -> both hit; touch 0x1000, miss
//   0x3000 -> evicts 0x2000 way; 0x1000 still hits.
//  peek_miss=0, peek_rdata=0xDEADBEEF on cold addr -> miss=0, no l2_rreq.
//  invalid_req for 0x1000 line mid-FILL -> fill completes, 0x1000 misses again
//   with new l2_rreq.
//  flush_req with 4 valid lines -> all subsequent lookups miss.
//  reset low during WAIT -> l2_rreq=0, state IDLE, prior lines miss.

Source files
------------

// File: rtl/icache_assoc_pkg.sv
// Shared types for the set-associative instruction cache.
// Refill FSM state encoding and geometry helper.
package icache_assoc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FILL = 2'd3
    } state_e;

    function automatic int tag_width(int set_bits, int word_bits);
        return 30 - set_bits - word_bits;
    endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch, DCache-peek, L2-refill and invalidate bus of the icache.
// slave: cache side; master: fetch/L2/coherence side.
interface icache_assoc_if #(
    parameter int LINE_W = 27
);
    logic              rreq;
    logic [31:0]       addr;
    logic [31:0]       rdata;
    logic              miss;
    logic [31:0]       peek_addr;
    logic [31:0]       peek_rdata;
    logic              peek_miss;
    logic              l2_rreq;
    logic [31:0]       l2_addr;
    logic [4:0]        l2_burst_size;
    logic [31:0]       l2_rdata;
    logic              l2_busy;
    logic [LINE_W-1:0] invalid_line;
    logic              invalid_req;
    logic              flush_req;

    modport slave (
        input  rreq, addr, peek_rdata, peek_miss,
        input  l2_rdata, l2_busy,
        input  invalid_line, invalid_req, flush_req,
        output rdata, miss, peek_addr,
        output l2_rreq, l2_addr, l2_burst_size
    );

    modport master (
        output rreq, addr, peek_rdata, peek_miss,
        output l2_rdata, l2_busy,
        output invalid_line, invalid_req, flush_req,
        input  rdata, miss, peek_addr,
        input  l2_rreq, l2_addr, l2_burst_size
    );
endinterface

// File: rtl/icache_assoc_way.sv
// One cache way: tag/valid/data arrays, hit compare, word read,
// fill write port, invalidate and flush. Only valid bits are reset.
module icache_assoc_way #(
    parameter int SET_BITS  = 4,
    parameter int WORD_BITS = 3,
    parameter int TAG_W     = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SET_BITS-1:0]  rd_set,
    input  logic [TAG_W-1:0]     rd_tag,
    input  logic [WORD_BITS-1:0] rd_word,
    output logic                 hit,
    output logic                 vld,
    output logic [31:0]          rdata,
    input  logic [SET_BITS-1:0]  wr_set,
    input  logic                 alloc_we,
    input  logic [TAG_W-1:0]     alloc_tag,
    input  logic                 fill_we,
    input  logic [WORD_BITS-1:0] fill_word,
    input  logic [31:0]          fill_data,
    input  logic                 fill_done,
    input  logic                 inv_req,
    input  logic [SET_BITS-1:0]  inv_set,
    input  logic [TAG_W-1:0]     inv_tag,
    input  logic                 flush
);
    localparam int SETS  = 2 ** SET_BITS;
    localparam int WORDS = SETS * (2 ** WORD_BITS);

    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [WORDS];

    assign vld   = valid_q[rd_set];
    assign hit   = vld && (tag_q[rd_set] == rd_tag);
    assign rdata = data_q[{rd_set, rd_word}];

    // Later assignments win: an invalidate or flush landing on the
    // completion cycle leaves the line invalid.
    always_comb begin
        valid_d = valid_q;
        if (alloc_we)
            valid_d[wr_set] = 1'b0;
        if (fill_done)
            valid_d[wr_set] = 1'b1;
        if (inv_req && tag_q[inv_set] == inv_tag)
            valid_d[inv_set] = 1'b0;
        if (flush)
            valid_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            valid_q <= '0;
        else
            valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (alloc_we)
            tag_q[wr_set] <= alloc_tag;
        if (fill_we)
            data_q[{wr_set, fill_word}] <= fill_data;
    end
endmodule

// File: rtl/icache_assoc.sv
// N-way (1/2) set-associative L1 icache with DCache peek, L2 burst
// refill, LRU, flush and refill poisoning. Ports: clk, reset, bus.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int SET_BITS  = 4,
    parameter int WORD_BITS = 3,
    parameter int WAYS      = 2
) (
    input logic           clk,
    input logic           reset,
    icache_assoc_if.slave bus
);
    localparam int LINE_WORDS = 2 ** WORD_BITS;
    localparam int TAG_W      = tag_width(SET_BITS, WORD_BITS);
    localparam int LINE_W     = TAG_W + SET_BITS;
    localparam int SETS       = 2 ** SET_BITS;
    localparam logic [WORD_BITS-1:0] LAST = WORD_BITS'(LINE_WORDS - 1);

    logic [SET_BITS-1:0]  cur_set, inv_set, wr_set;
    logic [TAG_W-1:0]     cur_tag, inv_tag;
    logic [WORD_BITS-1:0] cur_word, fill_word;
    logic [LINE_W-1:0]    inv_line;

    assign cur_set  = bus.addr[WORD_BITS+2 +: SET_BITS];
    assign cur_tag  = bus.addr[31 -: TAG_W];
    assign cur_word = bus.addr[2 +: WORD_BITS];
    assign inv_line = bus.invalid_line;
    assign inv_set  = inv_line[SET_BITS-1:0];
    assign inv_tag  = inv_line[LINE_W-1 -: TAG_W];

    state_e               state_q, state_d;
    logic [LINE_W-1:0]    line_q, line_d;
    logic                 way_q, way_d;
    logic [WORD_BITS-1:0] cnt_q, cnt_d;
    logic                 poison_q, poison_d;
    logic [SETS-1:0]      lru_q, lru_d;
    logic                 l2_rreq_q, l2_rreq_d;
    logic [31:0]          l2_addr_q, l2_addr_d;
    logic [4:0]           l2_bs_q, l2_bs_d;

    logic [WAYS-1:0] hit_w, vld_w;
    logic [31:0]     rdata_w [WAYS];
    logic            hit, hit_way, victim;
    logic [31:0]     rdata_hit;
    logic            start, fill_we, fill_done;

    assign start     = state_q == S_IDLE && bus.rreq
                    && bus.peek_miss && !hit;
    assign fill_we   = (state_q == S_WAIT && !bus.l2_busy)
                    || state_q == S_FILL;
    assign fill_word = (state_q == S_FILL) ? cnt_q : '0;
    assign fill_done = state_q == S_FILL && cnt_q == LAST;
    assign wr_set    = start ? cur_set : line_q[SET_BITS-1:0];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_assoc_way #(
            .SET_BITS  (SET_BITS),
            .WORD_BITS (WORD_BITS),
            .TAG_W     (TAG_W)
        ) u_way (
            .clk       (clk),
            .reset     (reset),
            .rd_set    (cur_set),
            .rd_tag    (cur_tag),
            .rd_word   (cur_word),
            .hit       (hit_w[w]),
            .vld       (vld_w[w]),
            .rdata     (rdata_w[w]),
            .wr_set    (wr_set),
            .alloc_we  (start && victim == 1'(w)),
            .alloc_tag (cur_tag),
            .fill_we   (fill_we && way_q == 1'(w)),
            .fill_word (fill_word),
            .fill_data (bus.l2_rdata),
            .fill_done (fill_done && way_q == 1'(w) && !poison_q),
            .inv_req   (bus.invalid_req),
            .inv_set   (inv_set),
            .inv_tag   (inv_tag),
            .flush     (bus.flush_req)
        );
    end

    // Hit-way mux and victim choice: first invalid way, else LRU.
    always_comb begin
        hit       = 1'b0;
        hit_way   = 1'b0;
        rdata_hit = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_w[w]) begin
                hit       = 1'b1;
                hit_way   = 1'(w);
                rdata_hit = rdata_w[w];
            end
        end
        victim = 1'b0;
        if (WAYS == 2 && vld_w[0])
            victim = vld_w[WAYS-1] ? lru_q[cur_set] : 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_REQ;
            S_REQ:   state_d = S_WAIT;
            S_WAIT:  if (!bus.l2_busy) state_d = S_FILL;
            S_FILL:  if (cnt_q == LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        line_d    = line_q;
        way_d     = way_q;
        cnt_d     = cnt_q;
        poison_d  = poison_q;
        lru_d     = lru_q;
        l2_rreq_d = start;
        l2_addr_d = l2_addr_q;
        l2_bs_d   = l2_bs_q;
        if (start) begin
            line_d    = {cur_tag, cur_set};
            way_d     = victim;
            l2_addr_d = {cur_tag, cur_set, {(WORD_BITS+2){1'b0}}};
            l2_bs_d   = 5'(LINE_WORDS);
            if (WAYS == 2)
                lru_d[cur_set] = ~victim;
        end
        if (state_q == S_IDLE && bus.rreq && hit && WAYS == 2)
            lru_d[cur_set] = ~hit_way;
        if (fill_we)
            cnt_d = fill_word + WORD_BITS'(1);
        // line_d already holds the new tag on a start cycle, so an
        // invalidate arriving with the start poisons the refill.
        if (fill_done) begin
            poison_d = 1'b0;
        end else begin
            if (bus.flush_req && state_q != S_IDLE)
                poison_d = 1'b1;
            if (bus.invalid_req && inv_line == line_d
                && (start || state_q != S_IDLE))
                poison_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_q    <= '0;
            way_q     <= 1'b0;
            cnt_q     <= '0;
            poison_q  <= 1'b0;
            lru_q     <= '0;
            l2_rreq_q <= 1'b0;
            l2_addr_q <= '0;
            l2_bs_q   <= '0;
        end else begin
            line_q    <= line_d;
            way_q     <= way_d;
            cnt_q     <= cnt_d;
            poison_q  <= poison_d;
            lru_q     <= lru_d;
            l2_rreq_q <= l2_rreq_d;
            l2_addr_q <= l2_addr_d;
            l2_bs_q   <= l2_bs_d;
        end
    end

    assign bus.rdata         = bus.peek_miss ? rdata_hit : bus.peek_rdata;
    assign bus.miss          = (bus.rreq && bus.peek_miss && !hit)
                            || state_q != S_IDLE;
    assign bus.peek_addr     = bus.addr;
    assign bus.l2_rreq       = l2_rreq_q;
    assign bus.l2_addr       = l2_addr_q;
    assign bus.l2_burst_size = l2_bs_q;
endmodule
